router_fifo_depacketizer: RTL

Receive-side counterpart of the FIFO-to-router packetizer: it takes flits (HEAD/BODY/TAIL/HEADTAIL) leaving a router local port and rebuilds the FIFO word stream in the packetizer's ingress format. That stream is one header word with the destination, the data length and the head payload, followed by the data words. The block is store-and-forward: a packet is emitted only once its TAIL has been accepted, so the header's length field is exact. It sits between a router local output port and the DLA-side write FIFO.

---
 rtl/router_fifo_depacketizer_if.sv | 29 ++
 rtl/router_fifo_depacketizer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/router_fifo_depacketizer_if.sv
// Router local-port / DLA write-FIFO bus bundle for router_fifo_depacketizer.
// Flit layout (MSB..LSB): {label[1:0], vc_id[VC_W-1:0], data[FLIT_DATA_SIZE-1:0]}.
// Labels: 2'b00 HEAD, 2'b01 BODY, 2'b10 TAIL, 2'b11 HEADTAIL.
// The master modport is the depacketizer side; slave is the router/FIFO side.
interface router_fifo_depacketizer_if #(
   parameter int unsigned FLIT_DATA_SIZE = 32,
   parameter int unsigned VC_NUM         = 2
);
   localparam int unsigned VC_W   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
   localparam int unsigned FLIT_W = 2 + VC_W + FLIT_DATA_SIZE;

   logic [FLIT_W-1:0]         router_data_out;
   logic                      router_valid_out;
   logic [VC_NUM-1:0]         router_is_on_off_in;
   logic [VC_NUM-1:0]         router_is_allocatable_in;
   logic                      router2fifo_en;
   logic [FLIT_DATA_SIZE-1:0] router2fifo_data;
   logic                      router_write_buffer_afull;

   modport master (
      input  router_data_out, router_valid_out, router_write_buffer_afull,
      output router_is_on_off_in, router_is_allocatable_in, router2fifo_en, router2fifo_data
   );

   modport slave (
      output router_data_out, router_valid_out, router_write_buffer_afull,
      input  router_is_on_off_in, router_is_allocatable_in, router2fifo_en, router2fifo_data
   );
endinterface

// File: rtl/router_fifo_depacketizer.sv
// Store-and-forward depacketizer: router flits -> {header word, data words} FIFO stream.
// HEAD/HEADTAIL data field: x [FSZ-1:FSZ-4], y [FSZ-5:FSZ-8], l [FSZ-9:FSZ-11],
// head_pl [FSZ-20:0]; bits [FSZ-12:FSZ-19] are ignored (that slot carries len on output).
// Optional feature: define DEPKT_STATS_EN for live stat_pkt_cnt / stat_drop_cnt counters.
module router_fifo_depacketizer #(
   parameter int unsigned DATA_DEPTH     = 64,
   parameter int unsigned HDR_DEPTH      = 2,
   parameter int unsigned ON_OFF_MARGIN  = 4,
   parameter int unsigned FLIT_DATA_SIZE = 32,
   parameter int unsigned VC_NUM         = 2
) (
   input  logic                        clk_router,
   input  logic                        rst_router,
   router_fifo_depacketizer_if.master  bus,
   output logic                        err_overflow,
   output logic [15:0]                 stat_pkt_cnt,
   output logic [15:0]                 stat_drop_cnt
);
   localparam int unsigned FSZ    = FLIT_DATA_SIZE;
   localparam int unsigned VC_W   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
   localparam int unsigned FLIT_W = 2 + VC_W + FSZ;
   localparam int unsigned PL_W   = FSZ - 19;
   localparam int unsigned DA_W   = $clog2(DATA_DEPTH);
   localparam int unsigned DC_W   = $clog2(DATA_DEPTH + 1);
   localparam int unsigned HA_W   = (HDR_DEPTH > 1) ? $clog2(HDR_DEPTH) : 1;
   localparam int unsigned HC_W   = $clog2(HDR_DEPTH + 1);

   localparam logic [1:0] FlitHead = 2'b00, FlitBody = 2'b01, FlitTail = 2'b10,
                          FlitHeadTail = 2'b11;

   typedef enum logic [1:0] {StIdle, StHdr, StData} state_e;

   typedef struct packed {
      logic [3:0]      x;
      logic [3:0]      y;
      logic [2:0]      l;
      logic [7:0]      len;
      logic            no_data;
      logic [PL_W-1:0] pl;
   } hdr_t;

   logic [FSZ-1:0]  d_mem [DATA_DEPTH];
   hdr_t            h_mem [HDR_DEPTH];
   logic [DA_W-1:0] d_wr_q, d_rd_q;
   logic [DC_W-1:0] d_cnt_q;
   logic [HA_W-1:0] h_wr_q, h_rd_q;
   logic [HC_W-1:0] h_cnt_q;
   logic [3:0]      stg_x_q, stg_y_q;
   logic [2:0]      stg_l_q;
   logic [PL_W-1:0] stg_pl_q;
   logic [8:0]      cnt_q, rem_q, rem_d;
   state_e          state_q, state_d;
   logic            en_q, en_d;
   logic [FSZ-1:0]  data_q, data_d;
   logic            err_q;

   logic [1:0]      lbl;
   logic [FSZ-1:0]  fdat;
   logic            d_full, h_full, d_push, d_pop, h_push, h_pop, drop, stg_ld, cnt_inc;
   logic            pkt_inc, hdr_go, flow_ok;
   hdr_t            h_new, h_head;
   logic            unused_flit;

   assign lbl         = bus.router_data_out[FLIT_W-1 -: 2];
   assign fdat        = bus.router_data_out[FSZ-1:0];
   assign unused_flit = ^{bus.router_data_out[FSZ +: VC_W], fdat[FSZ-12 -: 8]};
   assign d_full      = (d_cnt_q == DC_W'(DATA_DEPTH));
   assign h_full      = (h_cnt_q == HC_W'(HDR_DEPTH));
   assign h_head      = h_mem[h_rd_q];

   // Write side: classify the incoming flit into staging / queue pushes / drop.
   always_comb begin
      d_push  = 1'b0;
      h_push  = 1'b0;
      drop    = 1'b0;
      stg_ld  = 1'b0;
      cnt_inc = 1'b0;
      h_new   = '0;
      if (bus.router_valid_out) begin
         unique case (lbl)
            FlitHead: stg_ld = 1'b1;
            FlitBody: begin
               // cnt_q[8] set means 256 words already staged; len could not encode more.
               if (d_full || cnt_q[8]) drop = 1'b1;
               else begin
                  d_push  = 1'b1;
                  cnt_inc = 1'b1;
               end
            end
            FlitTail: begin
               if (d_full || h_full || cnt_q[8]) drop = 1'b1;
               else begin
                  d_push = 1'b1;
                  h_push = 1'b1;
                  h_new  = '{x: stg_x_q, y: stg_y_q, l: stg_l_q, len: cnt_q[7:0],
                             no_data: 1'b0, pl: stg_pl_q};
               end
            end
            FlitHeadTail: begin
               stg_ld = 1'b1;
               if (h_full) drop = 1'b1;
               else begin
                  h_push = 1'b1;
                  h_new  = '{x: fdat[FSZ-1 -: 4], y: fdat[FSZ-5 -: 4], l: fdat[FSZ-9 -: 3],
                             len: 8'hFF, no_data: 1'b1, pl: fdat[PL_W-1:0]};
               end
            end
         endcase
      end
   end

   // Read FSM next state and registered-output next values.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      en_d    = 1'b0;
      data_d  = '0;
      d_pop   = 1'b0;
      h_pop   = 1'b0;
      pkt_inc = 1'b0;
      // Idle with a queued header emits at once, so the header leaves one edge after it lands.
      hdr_go  = !bus.router_write_buffer_afull &&
                ((state_q == StHdr) || (state_q == StIdle && h_cnt_q != '0));
      if (hdr_go) begin
         en_d   = 1'b1;
         data_d = {h_head.x, h_head.y, h_head.l, h_head.len, h_head.pl};
         if (h_head.no_data) begin
            h_pop   = 1'b1;
            pkt_inc = 1'b1;
            state_d = StIdle;
         end else begin
            rem_d   = {1'b0, h_head.len} + 9'd1;
            state_d = StData;
         end
      end else if (state_q == StIdle && h_cnt_q != '0) begin
         state_d = StHdr;
      end else if (state_q == StData && !bus.router_write_buffer_afull) begin
         en_d   = 1'b1;
         data_d = d_mem[d_rd_q];
         d_pop  = 1'b1;
         rem_d  = rem_q - 9'd1;
         if (rem_q == 9'd1) begin
            h_pop   = 1'b1;
            pkt_inc = 1'b1;
            state_d = (h_cnt_q > HC_W'(1)) ? StHdr : StIdle;
         end
      end
   end

   // Queue storage (no reset needed; validity is tracked by the pointers/counts).
   always_ff @(posedge clk_router) begin
      if (d_push) d_mem[d_wr_q] <= fdat;
      if (h_push) h_mem[h_wr_q] <= h_new;
   end

   // Pointers, counts, staging, FSM and registered outputs.
   always_ff @(posedge clk_router or posedge rst_router) begin
      if (rst_router) begin
         d_wr_q   <= '0;
         d_rd_q   <= '0;
         d_cnt_q  <= '0;
         h_wr_q   <= '0;
         h_rd_q   <= '0;
         h_cnt_q  <= '0;
         stg_x_q  <= '0;
         stg_y_q  <= '0;
         stg_l_q  <= '0;
         stg_pl_q <= '0;
         cnt_q    <= '0;
         rem_q    <= '0;
         state_q  <= StIdle;
         en_q     <= 1'b0;
         data_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         if (d_push) d_wr_q <= d_wr_q + DA_W'(1);
         if (d_pop)  d_rd_q <= d_rd_q + DA_W'(1);
         d_cnt_q <= d_cnt_q + DC_W'(d_push) - DC_W'(d_pop);
         if (h_push) h_wr_q <= (h_wr_q == HA_W'(HDR_DEPTH - 1)) ? '0 : h_wr_q + HA_W'(1);
         if (h_pop)  h_rd_q <= (h_rd_q == HA_W'(HDR_DEPTH - 1)) ? '0 : h_rd_q + HA_W'(1);
         h_cnt_q <= h_cnt_q + HC_W'(h_push) - HC_W'(h_pop);
         if (stg_ld) begin
            stg_x_q  <= fdat[FSZ-1 -: 4];
            stg_y_q  <= fdat[FSZ-5 -: 4];
            stg_l_q  <= fdat[FSZ-9 -: 3];
            stg_pl_q <= fdat[PL_W-1:0];
            cnt_q    <= '0;
         end else if (cnt_inc) begin
            cnt_q <= cnt_q + 9'd1;
         end
         rem_q   <= rem_d;
         state_q <= state_d;
         en_q    <= en_d;
         data_q  <= data_d;
         if (drop) err_q <= 1'b1;
      end
   end

   assign flow_ok = (DC_W'(DATA_DEPTH) - d_cnt_q > DC_W'(ON_OFF_MARGIN)) &&
                    (h_cnt_q < HC_W'(HDR_DEPTH));
   assign bus.router_is_on_off_in      = {VC_NUM{flow_ok}};
   assign bus.router_is_allocatable_in = {VC_NUM{1'b1}};
   assign bus.router2fifo_en           = en_q;
   assign bus.router2fifo_data         = data_q;
   assign err_overflow                 = err_q;

`ifdef DEPKT_STATS_EN
   logic [15:0] pkt_cnt_q, drop_cnt_q;

   // Saturating packet / drop statistics.
   always_ff @(posedge clk_router or posedge rst_router) begin
      if (rst_router) begin
         pkt_cnt_q  <= '0;
         drop_cnt_q <= '0;
      end else begin
         if (pkt_inc && pkt_cnt_q != 16'hFFFF) pkt_cnt_q <= pkt_cnt_q + 16'd1;
         if (drop && drop_cnt_q != 16'hFFFF)   drop_cnt_q <= drop_cnt_q + 16'd1;
      end
   end

   assign stat_pkt_cnt  = pkt_cnt_q;
   assign stat_drop_cnt = drop_cnt_q;
`else
   logic unused_stats;
   assign unused_stats  = pkt_inc;
   assign stat_pkt_cnt  = '0;
   assign stat_drop_cnt = '0;
`endif
endmodule
